// File: rtl/l0_skew_feeder_if.sv
// Bus bundle for the west-edge skew feeder: write vector, read wave, per-row outputs.
// Ports: wr/in (write), rd/inst_in (read wave), out/inst_out, o_full/o_empty (and o_err when L0_OVF_FLAG_EN).
interface l0_skew_feeder_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic               wr;
  logic [row*bw-1:0]  in;
  logic               rd;
  logic [1:0]         inst_in;
  logic [row*bw-1:0]  out;
  logic [row*2-1:0]   inst_out;
  logic               o_full;
  logic               o_empty;
`ifdef L0_OVF_FLAG_EN
  logic               o_err;

  modport master (
    output wr, in, rd, inst_in,
    input  out, inst_out, o_full, o_empty, o_err
  );

  modport slave (
    input  wr, in, rd, inst_in,
    output out, inst_out, o_full, o_empty, o_err
  );
`else
  modport master (
    output wr, in, rd, inst_in,
    input  out, inst_out, o_full, o_empty
  );

  modport slave (
    input  wr, in, rd, inst_in,
    output out, inst_out, o_full, o_empty
  );
`endif
endinterface

// File: rtl/l0_skew_feeder.sv
// West-edge L0 buffer: one FIFO per array row, drained as a diagonal skewed wave.
// Ports: clk, reset (async active-low), bus (slave modport). Optional o_err via L0_OVF_FLAG_EN.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic            clk,
  input  logic            reset,
  l0_skew_feeder_if.slave bus
);

  localparam int AW = $clog2(depth);

  logic [AW:0]       r_wptr [row];
  logic [AW:0]       r_rptr [row];
  logic [bw-1:0]     r_mem  [row][depth];

  // Stage i of the delay line feeds row i+1; row 0 uses rd directly.
  logic              r_dl_rd   [row-1];
  logic [1:0]        r_dl_inst [row-1];

  logic [row*bw-1:0] r_out;
  logic [row*2-1:0]  r_inst;

  logic [row-1:0]    w_stb;
  logic [1:0]        w_inst [row];
  logic [row-1:0]    w_empty;
  logic              w_full;
  logic              w_wen;

  always_comb begin
    w_stb     = '0;
    w_empty   = '0;
    w_stb[0]  = bus.rd;
    w_inst[0] = bus.inst_in;
    for (int r = 1; r < row; r++) begin
      w_stb[r]  = r_dl_rd[r-1];
      w_inst[r] = r_dl_inst[r-1];
    end
    for (int r = 0; r < row; r++) begin
      w_empty[r] = (r_wptr[r] == r_rptr[r]);
    end
  end

  // Last row lags the most, so it holds the most entries.
  assign w_full = ((r_wptr[row-1] ^ r_rptr[row-1])
                   == {1'b1, {AW{1'b0}}});
  assign w_wen  = bus.wr & ~w_full;

  assign bus.o_full   = w_full;
  assign bus.o_empty  = w_empty[0];
  assign bus.out      = r_out;
  assign bus.inst_out = r_inst;

  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int r = 0; r < row; r++) begin
        r_mem[r][r_wptr[r][AW-1:0]] <= bus.in[r*bw +: bw];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < row; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
      end
      for (int i = 0; i < row-1; i++) begin
        r_dl_rd[i]   <= 1'b0;
        r_dl_inst[i] <= 2'b00;
      end
      r_out  <= '0;
      r_inst <= '0;
    end else begin
      for (int i = row-2; i > 0; i--) begin
        r_dl_rd[i]   <= r_dl_rd[i-1];
        r_dl_inst[i] <= r_dl_inst[i-1];
      end
      r_dl_rd[0]   <= bus.rd;
      r_dl_inst[0] <= bus.inst_in;
      for (int r = 0; r < row; r++) begin
        if (w_wen) begin
          r_wptr[r] <= r_wptr[r] + 1'b1;
        end
        // An empty row keeps its data lane but idles the tile.
        if (w_stb[r] && !w_empty[r]) begin
          r_rptr[r]          <= r_rptr[r] + 1'b1;
          r_out[r*bw +: bw]  <= r_mem[r][r_rptr[r][AW-1:0]];
          r_inst[r*2 +: 2]   <= w_inst[r];
        end else begin
          r_inst[r*2 +: 2]   <= 2'b00;
        end
      end
    end
  end

`ifdef L0_OVF_FLAG_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (bus.wr & w_full) | (|(w_stb & w_empty));
  assign bus.o_err = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed self-checking bench for l0_skew_feeder.
// Covers reset, skewed wave, full/empty limits, empty reads, wrap, async reset mid-wave.
module tb_l0_skew_feeder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  l0_skew_feeder_if #(.row(8), .bw(4)) bif ();

  l0_skew_feeder #(.row(8), .bw(4), .depth(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] vec(input int i);
    logic [31:0] v;
    for (int r = 0; r < 8; r++) v[r*4 +: 4] = 4'(i*3 + r*5);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.wr      = 1'b0;
    bif.rd      = 1'b0;
    bif.inst_in = 2'b00;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bif.in      = '0;
    idle();
    repeat (3) tick();
    checks++;
    if (bif.out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got %h expected 00000000", bif.out);
    end
    checks++;
    if (bif.inst_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_inst: got %h expected 0000", bif.inst_out);
    end
    checks++;
    if (bif.o_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 1", bif.o_empty);
    end
    checks++;
    if (bif.o_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full: got %b expected 0", bif.o_full);
    end
`ifdef L0_OVF_FLAG_EN
    checks++;
    if (bif.o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bif.o_err);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_wave();
    logic [15:0] ei;
    bif.wr = 1'b1;
    bif.in = 32'h87654321;
    tick();
    bif.wr      = 1'b0;
    bif.rd      = 1'b1;
    bif.inst_in = 2'b10;
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      ei = 16'h0002 << (2*k);
      checks++;
      if (bif.out[k*4 +: 4] !== 4'(k+1)) begin
        errors++;
        $display("FAIL wave_out row%0d: got %h expected %h",
                 k, bif.out[k*4 +: 4], 4'(k+1));
      end
      checks++;
      if (bif.inst_out !== ei) begin
        errors++;
        $display("FAIL wave_inst t%0d: got %h expected %h",
                 k, bif.inst_out, ei);
      end
      if (k == 0) begin
        checks++;
        if (bif.o_empty !== 1'b1) begin
          errors++;
          $display("FAIL wave_empty: got %b expected 1", bif.o_empty);
        end
      end
    end
    checks++;
    if (bif.out !== 32'h87654321) begin
      errors++;
      $display("FAIL wave_final: got %h expected 87654321", bif.out);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 16; k++) begin
      bif.wr = 1'b1;
      bif.in = {8{4'(k)}};
      tick();
      if (k == 14) begin
        checks++;
        if (bif.o_full !== 1'b0) begin
          errors++;
          $display("FAIL full_early: got %b expected 0", bif.o_full);
        end
      end
    end
    checks++;
    if (bif.o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set: got %b expected 1", bif.o_full);
    end
    bif.in = {8{4'hF}};
    tick();
    checks++;
    if (bif.o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: got %b expected 1", bif.o_full);
    end
`ifdef L0_OVF_FLAG_EN
    checks++;
    if (bif.o_err !== 1'b1) begin
      errors++;
      $display("FAIL full_err: got %b expected 1", bif.o_err);
    end
`endif
    bif.wr      = 1'b0;
    bif.rd      = 1'b1;
    bif.inst_in = 2'b10;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (bif.out[3:0] !== 4'(k)) begin
        errors++;
        $display("FAIL full_rd%0d: got %h expected %h",
                 k, bif.out[3:0], 4'(k));
      end
    end
    checks++;
    if (bif.o_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_empty: got %b expected 1", bif.o_empty);
    end
    idle();
    repeat (8) tick();
    checks++;
    if (bif.out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL full_drain: got %h expected ffffffff", bif.out);
    end
    checks++;
    if (bif.o_full !== 1'b0) begin
      errors++;
      $display("FAIL full_clear: got %b expected 0", bif.o_full);
    end
  endtask

  task automatic test_empty_rd();
    bif.rd      = 1'b1;
    bif.inst_in = 2'b01;
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checks++;
      if (bif.inst_out !== 16'h0) begin
        errors++;
        $display("FAIL empty_inst t%0d: got %h expected 0000",
                 k, bif.inst_out);
      end
      checks++;
      if (bif.out !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL empty_out t%0d: got %h expected ffffffff",
                 k, bif.out);
      end
    end
`ifdef L0_OVF_FLAG_EN
    checks++;
    if (bif.o_err !== 1'b1) begin
      errors++;
      $display("FAIL empty_err: got %b expected 1", bif.o_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev;
    logic [1:0]  es;
    int          idx;
    bif.wr = 1'b1;
    bif.in = vec(0);
    tick();
    for (int e = 1; e <= 47; e++) begin
      if (e <= 40) begin
        bif.wr      = 1'b1;
        bif.in      = vec(e);
        bif.rd      = 1'b1;
        bif.inst_in = 2'b10;
      end else begin
        idle();
      end
      tick();
      for (int r = 0; r < 8; r++) begin
        idx = e - r - 1;
        es  = (idx >= 0 && idx <= 39) ? 2'b10 : 2'b00;
        checks++;
        if (bif.inst_out[r*2 +: 2] !== es) begin
          errors++;
          $display("FAIL b2b_inst e%0d r%0d: got %b expected %b",
                   e, r, bif.inst_out[r*2 +: 2], es);
        end
        if (idx >= 0 && idx <= 39) begin
          ev = vec(idx);
          checks++;
          if (bif.out[r*4 +: 4] !== ev[r*4 +: 4]) begin
            errors++;
            $display("FAIL b2b_out e%0d r%0d: got %h expected %h",
                     e, r, bif.out[r*4 +: 4], ev[r*4 +: 4]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midwave();
    for (int k = 0; k < 3; k++) begin
      bif.wr = 1'b1;
      bif.in = vec(50 + k);
      tick();
    end
    bif.wr      = 1'b0;
    bif.rd      = 1'b1;
    bif.inst_in = 2'b10;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (bif.inst_out !== 16'h0020) begin
      errors++;
      $display("FAIL mid_pre: got %h expected 0020", bif.inst_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bif.out !== 32'h0 || bif.inst_out !== 16'h0) begin
      errors++;
      $display("FAIL mid_async: got %h/%h expected 0/0",
               bif.out, bif.inst_out);
    end
    checks++;
    if (bif.o_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_empty: got %b expected 1", bif.o_empty);
    end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bif.out !== 32'h0 || bif.inst_out !== 16'h0) begin
        errors++;
        $display("FAIL mid_after t%0d: got %h/%h expected 0/0",
                 k, bif.out, bif.inst_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bif.in = '0;
    idle();
    test_reset();
    test_wave();
    test_full();
    test_empty_rd();
    test_back_to_back();
    test_reset_midwave();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
